// File: rtl/fir_mem_responder.sv
// FIR request-port responder: services val/adr/dat/wrt requests from a local
// word memory, returns read data in order after a fixed latency, and can throttle
// accepts with a forced idle gap and a cap on outstanding reads.
module fir_mem_responder #(
  parameter logic [31:0] BASE    = 32'h3800_0000,
  parameter int          AW      = 6,
  parameter int          RD_LAT  = 2,
  parameter int          MAX_OUT = 4,
  parameter int          ACC_GAP = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rq_val,
  input  logic [31:0] rq_adr,
  input  logic [31:0] rq_dat,
  input  logic        rq_wrt,
  input  logic        rq_fin,
  output logic        rq_acc,
  output logic        rs_val,
  output logic [31:0] rs_dat,
  output logic        err,
  output logic        done,
  output logic [15:0] wr_cnt,
  output logic [15:0] rd_cnt
);

  typedef enum logic [1:0] {IDLE, GAP, DONE} state_t;

  localparam int          WORDS     = 1 << AW;
  localparam logic [31:0] SPAN      = 32'(4 * WORDS);
  localparam logic [2:0]  MAX_OUT_C = 3'(MAX_OUT);
  localparam logic [2:0]  GAP_LOAD  = 3'((ACC_GAP > 0) ? ACC_GAP - 1 : 0);
  localparam logic [31:0] MISS_DATA = 32'hDEAD_BEEF;

  state_t        state, state_next;
  logic [2:0]    gap_cnt, gap_cnt_next;
  logic [2:0]    outstanding;
  logic [2:0]    out_live;
  logic [31:0]   mem [WORDS];
  logic [RD_LAT-1:0] val_pipe;
  logic [31:0]   dat_pipe [RD_LAT];

  logic [31:0]   offset;
  logic          hit;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic          accept;
  logic          wr_acc;
  logic          rd_acc;

  // Window decode: aligned byte address inside [BASE, BASE + 4*WORDS).
  assign offset  = rq_adr - BASE;
  assign hit     = (rq_adr >= BASE) && (offset < SPAN) && (rq_adr[1:0] == 2'b00);
  assign idx     = offset[AW+1:2];
  assign rd_word = hit ? mem[idx] : MISS_DATA;

  assign accept = rq_val && rq_acc;
  assign wr_acc = accept && rq_wrt;
  assign rd_acc = accept && !rq_wrt;

  // A response leaving this cycle frees its slot, so a new read may take it now.
  assign out_live = outstanding - {2'b00, rs_val};

  assign rs_val = val_pipe[RD_LAT-1];
  assign rs_dat = dat_pipe[RD_LAT-1];

  // FSM state and gap counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      // NOTE: every clocked block uses non-blocking assignments so all registers
      // update from the same pre-edge values regardless of block ordering.
      state   <= state_next;
      gap_cnt <= gap_cnt_next;
    end
  end

  // Next-state logic and the combinational accept strobe.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch forms.
    state_next   = state;
    gap_cnt_next = gap_cnt;
    rq_acc       = 1'b0;
    case (state)
      IDLE: begin
        rq_acc = rq_val && (rq_wrt || (out_live < MAX_OUT_C));
        if (rq_acc && (ACC_GAP > 0)) begin
          state_next   = GAP;
          gap_cnt_next = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_cnt == 3'd0) state_next = IDLE;
        else                 gap_cnt_next = gap_cnt - 3'd1;
      end
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
    if (rq_fin) state_next = DONE;
  end

  // Word memory: written on a hit write accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the memory is deliberately cleared on reset so a window always reads
      // back zero after reset; this forces flops rather than a RAM macro.
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (wr_acc && hit) begin
      mem[idx] <= rq_dat;
    end
  end

  // Read response pipeline; data stages only load behind a valid so rs_dat holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_pipe <= '0;
      for (int i = 0; i < RD_LAT; i++) dat_pipe[i] <= '0;
    end else begin
      val_pipe[0] <= rd_acc;
      if (rd_acc) dat_pipe[0] <= rd_word;
      for (int i = 1; i < RD_LAT; i++) begin
        val_pipe[i] <= val_pipe[i-1];
        if (val_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  // Outstanding read count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
    end else begin
      case ({rd_acc, rs_val})
        2'b10:   outstanding <= outstanding + 3'd1;
        2'b01:   outstanding <= outstanding - 3'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Sticky flags and wrapping accept counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err    <= 1'b0;
      done   <= 1'b0;
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (accept && !hit) err  <= 1'b1;
      if (rq_fin)         done <= 1'b1;
      if (wr_acc)         wr_cnt <= wr_cnt + 16'd1;
      if (rd_acc)         rd_cnt <= rd_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fir_mem_responder.sv
// Bench for fir_mem_responder: three instances (default, ACC_GAP=3,
// MAX_OUT=1/RD_LAT=3) driven by directed steps, with an in-order scoreboard of
// expected read responses (data and arrival cycle).
module tb_fir_mem_responder;

  localparam logic [31:0] BASE = 32'h3800_0000;
  localparam logic [31:0] MISS = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  val = '0, wrt = '0, fin = '0;
  logic [31:0] adr [3];
  logic [31:0] dat [3];
  logic [2:0]  acc, rsv, errv, donev;
  logic [31:0] rsd [3];
  logic [15:0] wrc [3];
  logic [15:0] rdc [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          k;
    logic [31:0] dat;
    int          cyc;
  } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_mem_responder dut_a (
    .clk(clk), .rst(rst), .rq_val(val[0]), .rq_adr(adr[0]), .rq_dat(dat[0]),
    .rq_wrt(wrt[0]), .rq_fin(fin[0]), .rq_acc(acc[0]), .rs_val(rsv[0]), .rs_dat(rsd[0]),
    .err(errv[0]), .done(donev[0]), .wr_cnt(wrc[0]), .rd_cnt(rdc[0]));

  fir_mem_responder #(.ACC_GAP(3)) dut_g (
    .clk(clk), .rst(rst), .rq_val(val[1]), .rq_adr(adr[1]), .rq_dat(dat[1]),
    .rq_wrt(wrt[1]), .rq_fin(fin[1]), .rq_acc(acc[1]), .rs_val(rsv[1]), .rs_dat(rsd[1]),
    .err(errv[1]), .done(donev[1]), .wr_cnt(wrc[1]), .rd_cnt(rdc[1]));

  fir_mem_responder #(.MAX_OUT(1), .RD_LAT(3)) dut_m (
    .clk(clk), .rst(rst), .rq_val(val[2]), .rq_adr(adr[2]), .rq_dat(dat[2]),
    .rq_wrt(wrt[2]), .rq_fin(fin[2]), .rq_acc(acc[2]), .rs_val(rsv[2]), .rs_dat(rsd[2]),
    .err(errv[2]), .done(donev[2]), .wr_cnt(wrc[2]), .rd_cnt(rdc[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: every rs_val must match the oldest expected entry.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rsv[k]) begin
        logic ok;
        exp_t e;
        ok = (sb.size() > 0) && (sb[0].k == k);
        check($sformatf("rs_val_expected[%0d]", k), {31'b0, ok}, 32'd1);
        if (ok) begin
          e = sb.pop_front();
          check($sformatf("rs_dat[%0d]", k), rsd[k], e.dat);
          check($sformatf("rs_cycle[%0d]", k), cyc, e.cyc);
        end
      end
    end
  end

  // Present a request from a negedge and hold it until accepted (bounded).
  task automatic req(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input int lat, output int acc_cyc);
    val[k] = 1'b1; wrt[k] = w; adr[k] = a; dat[k] = d;
    acc_cyc = -1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (acc[k]) begin
        acc_cyc = cyc;
        if (!w) sb.push_back('{k, exp, cyc + lat});
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    check("accept_in_budget", {31'b0, acc_cyc != -1}, 32'd1);
  endtask

  task automatic idle(input int k);
    val[k] = 1'b0; wrt[k] = 1'b0;
  endtask

  initial begin
    int ac [8];
    int t;
    for (int k = 0; k < 3; k++) begin adr[k] = '0; dat[k] = '0; end

    // Reset state of all instances.
    #1;
    for (int k = 0; k < 3; k++) begin
      check("rst_acc",  {31'b0, acc[k]},   32'd0);
      check("rst_rsv",  {31'b0, rsv[k]},   32'd0);
      check("rst_rsd",  rsd[k],            32'd0);
      check("rst_err",  {31'b0, errv[k]},  32'd0);
      check("rst_done", {31'b0, donev[k]}, 32'd0);
      check("rst_wrc",  {16'b0, wrc[k]},   32'd0);
      check("rst_rdc",  {16'b0, rdc[k]},   32'd0);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // Write then read the same word on consecutive cycles.
    req(0, 1'b1, BASE + 32'h4, 32'h0000_0005, '0, 2, ac[0]);
    req(0, 1'b0, BASE + 32'h4, '0, 32'h0000_0005, 2, ac[1]);
    idle(0);
    check("wr_rd_consecutive", ac[1] - ac[0], 32'd1);
    repeat (5) @(negedge clk);
    check("rs_dat_hold", rsd[0], 32'h0000_0005);
    check("wr_cnt_1", {16'b0, wrc[0]}, 32'd1);
    check("rd_cnt_1", {16'b0, rdc[0]}, 32'd1);

    // Top word of the window is a hit.
    req(0, 1'b1, BASE + 32'hFC, 32'hA5A5_0001, '0, 2, t);
    req(0, 1'b0, BASE + 32'hFC, '0, 32'hA5A5_0001, 2, t);
    idle(0);
    repeat (4) @(negedge clk);
    check("err_clean", {31'b0, errv[0]}, 32'd0);

    // Misses: one past the top, misaligned, below base, write miss.
    req(0, 1'b0, BASE + 32'h100, '0, MISS, 2, t);
    req(0, 1'b0, BASE + 32'h2, '0, MISS, 2, t);
    req(0, 1'b0, BASE - 32'h4, '0, MISS, 2, t);
    req(0, 1'b1, BASE + 32'h100, 32'h0000_0077, '0, 2, t);
    req(0, 1'b0, BASE, '0, 32'h0, 2, t);
    req(0, 1'b0, BASE + 32'h4, '0, 32'h0000_0005, 2, t);
    idle(0);
    repeat (4) @(negedge clk);
    check("err_sticky", {31'b0, errv[0]}, 32'd1);
    check("wr_cnt_3", {16'b0, wrc[0]}, 32'd3);
    check("rd_cnt_7", {16'b0, rdc[0]}, 32'd7);

    // ACC_GAP=3: writes then held reads, one accept every 4 cycles.
    for (int i = 0; i < 4; i++)
      req(1, 1'b1, BASE + 32'(4 * i), 32'hC0DE_0000 + 32'(i), '0, 2, ac[i]);
    for (int i = 0; i < 4; i++)
      req(1, 1'b0, BASE + 32'(4 * i), '0, 32'hC0DE_0000 + 32'(i), 2, ac[4 + i]);
    idle(1);
    for (int i = 1; i < 8; i++) check("gap_spacing", ac[i] - ac[i-1], 32'd4);
    repeat (6) @(negedge clk);

    // MAX_OUT=1, RD_LAT=3: next read accepted in the cycle of the previous rs_val.
    req(2, 1'b1, BASE, 32'h0000_0011, '0, 3, t);
    req(2, 1'b1, BASE + 32'h4, 32'h0000_0022, '0, 3, t);
    req(2, 1'b0, BASE, '0, 32'h0000_0011, 3, ac[0]);
    req(2, 1'b0, BASE + 32'h4, '0, 32'h0000_0022, 3, ac[1]);
    req(2, 1'b0, BASE, '0, 32'h0000_0011, 3, ac[2]);
    idle(2);
    check("maxout_spacing_1", ac[1] - ac[0], 32'd3);
    check("maxout_spacing_2", ac[2] - ac[1], 32'd3);
    repeat (6) @(negedge clk);

    // Reset with two reads in flight on the default instance.
    req(0, 1'b0, BASE + 32'h4, '0, 32'h0000_0005, 2, t);
    val[0] = 1'b1; wrt[0] = 1'b0; adr[0] = BASE + 32'h4;
    #1 check("second_read_acc", {31'b0, acc[0]}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    idle(0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_err",  {31'b0, errv[0]},  32'd0);
    check("post_rst_done", {31'b0, donev[0]}, 32'd0);
    check("post_rst_wrc",  {16'b0, wrc[0]},   32'd0);
    check("post_rst_rdc",  {16'b0, rdc[0]},   32'd0);
    req(0, 1'b0, BASE + 32'h4, '0, 32'h0, 2, t);
    idle(0);
    repeat (4) @(negedge clk);

    // Finish with reads in flight; the read on the fin edge is still serviced.
    req(0, 1'b1, BASE + 32'hFC, 32'h1234_5678, '0, 2, t);
    req(0, 1'b0, BASE + 32'hFC, '0, 32'h1234_5678, 2, t);
    fin[0] = 1'b1;
    req(0, 1'b0, BASE + 32'h8, '0, 32'h0, 2, t);
    check("done_next_edge", {31'b0, donev[0]}, 32'd1);
    val[0] = 1'b1; wrt[0] = 1'b0; adr[0] = BASE;
    for (int i = 0; i < 4; i++) begin
      #1 check("done_no_acc", {31'b0, acc[0]}, 32'd0);
      @(negedge clk);
    end
    idle(0);
    fin[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("done_sticky", {31'b0, donev[0]}, 32'd1);
    check("done_rdc", {16'b0, rdc[0]}, 32'd3);
    check("done_wrc", {16'b0, wrc[0]}, 32'd1);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
